// File: rtl/tlul_flash_word_adapter.sv
// TL-UL device adapter: single-beat Get/PutFullData into one flash word access, one request outstanding.
// Latency: error response 1 cycle after accept; flash path responds 1 cycle after flash_ack_i. A-channel stalls until D handshake.
module tlul_flash_word_adapter #(
    parameter logic [31:0] BaseAddr      = 32'h2000_0000,
    parameter int          TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tl_a_valid_i,
    output logic        tl_a_ready_o,
    input  logic [2:0]  tl_a_opcode_i,
    input  logic [1:0]  tl_a_size_i,
    input  logic [7:0]  tl_a_source_i,
    input  logic [31:0] tl_a_address_i,
    input  logic [31:0] tl_a_data_i,
    output logic        tl_d_valid_o,
    input  logic        tl_d_ready_i,
    output logic [2:0]  tl_d_opcode_o,
    output logic [1:0]  tl_d_size_o,
    output logic [7:0]  tl_d_source_o,
    output logic        tl_d_sink_o,
    output logic [31:0] tl_d_data_o,
    output logic        tl_d_error_o,
    output logic        flash_req_o,
    output logic        flash_we_o,
    output logic        flash_bank_o,
    output logic [2:0]  flash_page_o,
    output logic [7:0]  flash_word_o,
    output logic [31:0] flash_wdata_o,
    input  logic        flash_ack_i,
    input  logic [31:0] flash_rdata_i,
    input  logic        flash_err_i
);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [7:0] TimeoutLast  = 8'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  size_q, size_d;
    logic [7:0]  src_q, src_d;
    logic [11:0] loc_q, loc_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic bad_req;
    logic is_get_q;

    // 16 KiB window, so the base match only involves address bits above bit 13.
    assign bad_req = ((tl_a_opcode_i != OpPutFull) && (tl_a_opcode_i != OpGet)) ||
                     (tl_a_size_i != 2'd2) ||
                     (tl_a_address_i[1:0] != 2'b00) ||
                     (tl_a_address_i[31:14] != BaseAddr[31:14]);

    assign is_get_q = (op_q == OpGet);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            size_q     <= 2'd0;
            src_q      <= 8'd0;
            loc_q      <= 12'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= 8'd0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            size_q     <= size_d;
            src_q      <= src_d;
            loc_q      <= loc_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        size_d     = size_q;
        src_d      = src_q;
        loc_d      = loc_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (tl_a_valid_i) begin
                    op_d       = tl_a_opcode_i;
                    size_d     = tl_a_size_i;
                    src_d      = tl_a_source_i;
                    loc_d      = tl_a_address_i[13:2];
                    wdata_d    = tl_a_data_i;
                    cnt_d      = 8'd0;
                    rsp_data_d = 32'd0;
                    rsp_err_d  = bad_req;
                    state_d    = bad_req ? RSP : REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                // An ack arriving on the timeout cycle still completes normally.
                if (flash_ack_i) begin
                    rsp_err_d  = flash_err_i;
                    rsp_data_d = (is_get_q && !flash_err_i) ? flash_rdata_i : 32'd0;
                    state_d    = RSP;
                end else if (cnt_q == TimeoutLast) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'd0;
                    state_d    = RSP;
                end
            end
            RSP: begin
                if (tl_d_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tl_a_ready_o  = (state_q == IDLE);

    assign tl_d_valid_o  = (state_q == RSP);
    assign tl_d_opcode_o = is_get_q ? 3'd1 : 3'd0;
    assign tl_d_size_o   = size_q;
    assign tl_d_source_o = src_q;
    assign tl_d_sink_o   = 1'b0;
    assign tl_d_data_o   = rsp_data_q;
    assign tl_d_error_o  = rsp_err_q;

    // Flash-side fields are only driven while a request is in flight.
    assign flash_req_o   = (state_q == REQ);
    assign flash_we_o    = flash_req_o && (op_q == OpPutFull);
    assign flash_bank_o  = flash_req_o & loc_q[11];
    assign flash_page_o  = flash_req_o ? loc_q[10:8] : 3'd0;
    assign flash_word_o  = flash_req_o ? loc_q[7:0] : 8'd0;
    assign flash_wdata_o = flash_req_o ? wdata_q : 32'd0;

endmodule

// File: tb/tb_tlul_flash_word_adapter.sv
// Directed bench for tlul_flash_word_adapter with a short timeout so the timeout path is reachable.
module tb_tlul_flash_word_adapter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        tl_a_valid_i;
    logic        tl_a_ready_o;
    logic [2:0]  tl_a_opcode_i;
    logic [1:0]  tl_a_size_i;
    logic [7:0]  tl_a_source_i;
    logic [31:0] tl_a_address_i;
    logic [31:0] tl_a_data_i;
    logic        tl_d_valid_o;
    logic        tl_d_ready_i;
    logic [2:0]  tl_d_opcode_o;
    logic [1:0]  tl_d_size_o;
    logic [7:0]  tl_d_source_o;
    logic        tl_d_sink_o;
    logic [31:0] tl_d_data_o;
    logic        tl_d_error_o;
    logic        flash_req_o;
    logic        flash_we_o;
    logic        flash_bank_o;
    logic [2:0]  flash_page_o;
    logic [7:0]  flash_word_o;
    logic [31:0] flash_wdata_o;
    logic        flash_ack_i;
    logic [31:0] flash_rdata_i;
    logic        flash_err_i;

    int n_cmp = 0;
    int n_bad = 0;

    tlul_flash_word_adapter #(
        .BaseAddr      (32'h2000_0000),
        .TimeoutCycles (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .tl_a_valid_i   (tl_a_valid_i),
        .tl_a_ready_o   (tl_a_ready_o),
        .tl_a_opcode_i  (tl_a_opcode_i),
        .tl_a_size_i    (tl_a_size_i),
        .tl_a_source_i  (tl_a_source_i),
        .tl_a_address_i (tl_a_address_i),
        .tl_a_data_i    (tl_a_data_i),
        .tl_d_valid_o   (tl_d_valid_o),
        .tl_d_ready_i   (tl_d_ready_i),
        .tl_d_opcode_o  (tl_d_opcode_o),
        .tl_d_size_o    (tl_d_size_o),
        .tl_d_source_o  (tl_d_source_o),
        .tl_d_sink_o    (tl_d_sink_o),
        .tl_d_data_o    (tl_d_data_o),
        .tl_d_error_o   (tl_d_error_o),
        .flash_req_o    (flash_req_o),
        .flash_we_o     (flash_we_o),
        .flash_bank_o   (flash_bank_o),
        .flash_page_o   (flash_page_o),
        .flash_word_o   (flash_word_o),
        .flash_wdata_o  (flash_wdata_o),
        .flash_ack_i    (flash_ack_i),
        .flash_rdata_i  (flash_rdata_i),
        .flash_err_i    (flash_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one request for exactly one edge; caller has checked a_ready.
    task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                        input logic [31:0] addr, input logic [31:0] dat);
        tl_a_valid_i   = 1'b1;
        tl_a_opcode_i  = op;
        tl_a_size_i    = sz;
        tl_a_source_i  = src;
        tl_a_address_i = addr;
        tl_a_data_i    = dat;
        tick();
        tl_a_valid_i   = 1'b0;
    endtask

    task automatic d_handshake(input string tag);
        tl_d_ready_i = 1'b1;
        tick();
        tl_d_ready_i = 1'b0;
        check_eq({tag, " d_valid after hs"}, 32'(tl_d_valid_o), 32'd0);
        check_eq({tag, " a_ready after hs"}, 32'(tl_a_ready_o), 32'd1);
    endtask

    logic [2:0]  bad_op   [4] = '{3'd4, 3'd4, 3'd4, 3'd1};
    logic [1:0]  bad_sz   [4] = '{2'd2, 2'd1, 2'd2, 2'd2};
    logic [31:0] bad_addr [4] = '{32'h2000_4000, 32'h2000_0000, 32'h2000_0002, 32'h2000_0100};
    logic [2:0]  bad_dop  [4] = '{3'd1, 3'd1, 3'd1, 3'd0};

    initial begin
        int n;
        rst_i = 1'b1;
        tl_a_valid_i = 1'b0; tl_a_opcode_i = 3'd0; tl_a_size_i = 2'd0; tl_a_source_i = 8'd0;
        tl_a_address_i = 32'd0; tl_a_data_i = 32'd0; tl_d_ready_i = 1'b0;
        flash_ack_i = 1'b0; flash_rdata_i = 32'd0; flash_err_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;

        check_eq("rst a_ready", 32'(tl_a_ready_o), 32'd1);
        check_eq("rst d_valid", 32'(tl_d_valid_o), 32'd0);
        check_eq("rst flash_req", 32'(flash_req_o), 32'd0);
        check_eq("rst flash_we", 32'(flash_we_o), 32'd0);
        check_eq("rst d_error", 32'(tl_d_error_o), 32'd0);
        check_eq("rst d_opcode", 32'(tl_d_opcode_o), 32'd0);

        // Get with ack on the third REQ cycle.
        send(3'd4, 2'd2, 8'h5A, 32'h2000_0404, 32'h0);
        check_eq("get req", 32'(flash_req_o), 32'd1);
        check_eq("get we", 32'(flash_we_o), 32'd0);
        check_eq("get bank", 32'(flash_bank_o), 32'd0);
        check_eq("get page", 32'(flash_page_o), 32'd1);
        check_eq("get word", 32'(flash_word_o), 32'd1);
        check_eq("get a_ready", 32'(tl_a_ready_o), 32'd0);
        tick(); tick();
        check_eq("get req held", 32'(flash_req_o), 32'd1);
        check_eq("get d_valid early", 32'(tl_d_valid_o), 32'd0);
        flash_ack_i = 1'b1; flash_rdata_i = 32'hDEAD_BEEF;
        tick();
        flash_ack_i = 1'b0; flash_rdata_i = 32'h0;
        check_eq("get d_valid", 32'(tl_d_valid_o), 32'd1);
        check_eq("get req dropped", 32'(flash_req_o), 32'd0);
        check_eq("get d_opcode", 32'(tl_d_opcode_o), 32'd1);
        check_eq("get d_data", tl_d_data_o, 32'hDEAD_BEEF);
        check_eq("get d_error", 32'(tl_d_error_o), 32'd0);
        check_eq("get d_source", 32'(tl_d_source_o), 32'h5A);
        check_eq("get d_size", 32'(tl_d_size_o), 32'd2);
        check_eq("get d_sink", 32'(tl_d_sink_o), 32'd0);
        d_handshake("get");

        // PutFullData to the last word, acked in the first REQ cycle.
        send(3'd0, 2'd2, 8'h11, 32'h2000_3FFC, 32'h1234_5678);
        check_eq("put we", 32'(flash_we_o), 32'd1);
        check_eq("put bank", 32'(flash_bank_o), 32'd1);
        check_eq("put page", 32'(flash_page_o), 32'd7);
        check_eq("put word", 32'(flash_word_o), 32'd255);
        check_eq("put wdata", flash_wdata_o, 32'h1234_5678);
        flash_ack_i = 1'b1; flash_rdata_i = 32'hFFFF_FFFF;
        tick();
        flash_ack_i = 1'b0; flash_rdata_i = 32'h0;
        check_eq("put d_valid", 32'(tl_d_valid_o), 32'd1);
        check_eq("put d_opcode", 32'(tl_d_opcode_o), 32'd0);
        check_eq("put d_data", tl_d_data_o, 32'd0);
        check_eq("put d_error", 32'(tl_d_error_o), 32'd0);
        check_eq("put d_source", 32'(tl_d_source_o), 32'h11);
        d_handshake("put");

        // Malformed requests never reach flash.
        for (int i = 0; i < 4; i++) begin
            send(bad_op[i], bad_sz[i], 8'(i + 1), bad_addr[i], 32'hCAFE_0000);
            check_eq($sformatf("bad%0d d_valid", i), 32'(tl_d_valid_o), 32'd1);
            check_eq($sformatf("bad%0d d_error", i), 32'(tl_d_error_o), 32'd1);
            check_eq($sformatf("bad%0d d_data", i), tl_d_data_o, 32'd0);
            check_eq($sformatf("bad%0d flash_req", i), 32'(flash_req_o), 32'd0);
            check_eq($sformatf("bad%0d d_opcode", i), 32'(tl_d_opcode_o), 32'(bad_dop[i]));
            check_eq($sformatf("bad%0d d_source", i), 32'(tl_d_source_o), 32'(i + 1));
            d_handshake("bad");
        end

        // Timeout: no ack, request held exactly four cycles.
        send(3'd4, 2'd2, 8'h33, 32'h2000_0808, 32'h0);
        n = 0;
        while (flash_req_o && n < 20) begin
            n++;
            tick();
        end
        check_eq("to req cycles", 32'(n), 32'd4);
        check_eq("to d_valid", 32'(tl_d_valid_o), 32'd1);
        check_eq("to d_error", 32'(tl_d_error_o), 32'd1);
        check_eq("to d_data", tl_d_data_o, 32'd0);

        // Backpressure with a stray ack and a waiting A request.
        tl_a_valid_i = 1'b1; tl_a_opcode_i = 3'd4; tl_a_size_i = 2'd2; tl_a_address_i = 32'h2000_0000;
        for (int i = 0; i < 5; i++) begin
            flash_ack_i = (i == 1); flash_rdata_i = 32'hAAAA_5555;
            tick();
            check_eq($sformatf("bp%0d d_valid", i), 32'(tl_d_valid_o), 32'd1);
            check_eq($sformatf("bp%0d d_error", i), 32'(tl_d_error_o), 32'd1);
            check_eq($sformatf("bp%0d d_data", i), tl_d_data_o, 32'd0);
            check_eq($sformatf("bp%0d d_source", i), 32'(tl_d_source_o), 32'h33);
            check_eq($sformatf("bp%0d a_ready", i), 32'(tl_a_ready_o), 32'd0);
        end
        tl_a_valid_i = 1'b0; flash_ack_i = 1'b0;
        d_handshake("to");

        // Reset while a flash access is in flight.
        send(3'd4, 2'd2, 8'h44, 32'h2000_0C00, 32'h0);
        check_eq("rstreq req", 32'(flash_req_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("rstreq flash_req", 32'(flash_req_o), 32'd0);
        check_eq("rstreq a_ready", 32'(tl_a_ready_o), 32'd1);
        check_eq("rstreq d_valid", 32'(tl_d_valid_o), 32'd0);
        flash_ack_i = 1'b1; flash_rdata_i = 32'h1111_2222;
        tick();
        flash_ack_i = 1'b0;
        tick();
        check_eq("rstreq no rsp", 32'(tl_d_valid_o), 32'd0);
        check_eq("rstreq still idle", 32'(tl_a_ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
